uart_echo_master: RTL and testbench

- Avalon-MM initiator that drives the 8-bit Avalon slave port of the board UART core; it is the bus-side counterpart of that core's responder.
- Detects received bytes via the UART status_irq, reads them, buffers them in a small FIFO, and writes each byte back (XOR-masked) for transmission.
- Replaces the push-button read/write pulse logic in the DE1 UART echo/loopback design.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_echo_master_sync_fifo.sv | 46 ++++
 rtl/uart_echo_master.sv | 118 +++++++++++
 tb/tb_uart_echo_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo master: bus width and FSM state encoding.
package uart_pkg;

  localparam int AVALON_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_echo_master_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; head entry is visible combinationally.
module sync_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   lvl
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign lvl     = wr_ptr_q - rd_ptr_q;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = rst && push && !full;
  assign do_pop  = rst && pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; equal pointers already mark it empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_echo_master.sv
// Avalon-MM initiator that reads received bytes from the UART core, buffers them,
// and writes them back XOR-masked for transmission.
module uart_echo_master
  import uart_pkg::*;
#(
  parameter int                   FIFO_AW  = 2,
  parameter logic [AVALON_DW-1:0] XOR_MASK = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 avalon_read,
  output logic                 avalon_write,
  output logic [AVALON_DW-1:0] avalon_writedata,
  input  logic [AVALON_DW-1:0] avalon_readdata,
  input  logic                 avalon_waitrequest,
  input  logic                 status_irq,
  input  logic                 status_err,
  output logic [15:0]          cnt_rx,
  output logic [7:0]           cnt_err,
  output logic [FIFO_AW:0]     fifo_lvl
);

  state_e               state_q;
  logic                 read_q;
  logic                 write_q;
  logic [AVALON_DW-1:0] wdata_q;
  logic [15:0]          cnt_rx_q;
  logic [7:0]           cnt_err_q;
  logic [7:0]           cnt_err_d;
  logic                 err_q;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AVALON_DW-1:0] fifo_dout;

  // A transfer completes on the cycle its request is high and the slave is not stalling.
  assign fifo_push = (state_q == RD) && !avalon_waitrequest;
  assign fifo_pop  = (state_q == WR) && !avalon_waitrequest;

  sync_fifo #(
    .AW (FIFO_AW),
    .DW (AVALON_DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (avalon_readdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .lvl   (fifo_lvl)
  );

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    cnt_err_d = cnt_err_q;
    if (status_err && !err_q && (cnt_err_q != 8'hFF)) cnt_err_d = cnt_err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q     <= 1'b0;
      cnt_err_q <= '0;
    end else begin
      err_q     <= status_err;
      cnt_err_q <= cnt_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      cnt_rx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && status_irq && !fifo_full) begin
            read_q  <= 1'b1;
            state_q <= RD;
          end else if (en && !fifo_empty) begin
            write_q <= 1'b1;
            wdata_q <= fifo_dout ^ XOR_MASK;
            state_q <= WR;
          end
        end
        RD: begin
          if (!avalon_waitrequest) begin
            read_q   <= 1'b0;
            cnt_rx_q <= cnt_rx_q + 16'd1;
            state_q  <= GAP;
          end
        end
        WR: begin
          if (!avalon_waitrequest) begin
            write_q <= 1'b0;
            state_q <= GAP;
          end
        end
        // One idle cycle lets the UART drop status_irq before the next decision.
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avalon_read      = read_q;
  assign avalon_write     = write_q;
  assign avalon_writedata = wdata_q;
  assign cnt_rx           = cnt_rx_q;
  assign cnt_err          = cnt_err_q;

endmodule

// File: tb/tb_uart_echo_master.sv
// Directed bench for uart_echo_master: a UART slave model feeds bytes and stalls,
// a scoreboard matches every transmitted byte against the bytes read.
module tb_uart_echo_master;

  localparam logic [7:0] MASK = 8'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       status_err = 1'b0;
  logic       status_irq = 1'b0;
  logic [7:0] avalon_readdata = 8'h00;
  logic       avalon_waitrequest = 1'b0;
  logic       avalon_read;
  logic       avalon_write;
  logic [7:0] avalon_writedata;
  logic [15:0] cnt_rx;
  logic [7:0]  cnt_err;
  logic [2:0]  fifo_lvl;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model state
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int   rd_stall = 0;
  int   wr_stall = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic rd_fire = 1'b0;
  logic wr_fire = 1'b0;
  logic [7:0] wr_data_seen = 8'h00;
  logic [7:0] wr_start = 8'h00;
  logic rd_prev = 1'b0;
  logic wr_prev = 1'b0;
  int   lvl_prev = 0;
  int   n_reads = 0;
  int   n_writes = 0;
  int   rd_hi = 0;
  int   wr_hi = 0;
  int   rd_when_full = 0;
  int   wdata_unstable = 0;
  int   max_lvl = 0;

  uart_echo_master #(
    .FIFO_AW  (2),
    .XOR_MASK (MASK)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .avalon_read        (avalon_read),
    .avalon_write       (avalon_write),
    .avalon_writedata   (avalon_writedata),
    .avalon_readdata    (avalon_readdata),
    .avalon_waitrequest (avalon_waitrequest),
    .status_irq         (status_irq),
    .status_err         (status_err),
    .cnt_rx             (cnt_rx),
    .cnt_err            (cnt_err),
    .fifo_lvl           (fifo_lvl)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART slave: retires the transfer that completed at the last rising edge, then
  // decides waitrequest for the next edge. Runs on the falling edge.
  always @(negedge clk) begin
    logic wait_v;
    logic [7:0] exp_b;
    if (rd_fire) begin
      if (rx_q.size() == 0) check("rd_without_irq", 1, 0);
      else begin
        exp_q.push_back(rx_q[0] ^ MASK);
        void'(rx_q.pop_front());
      end
      n_reads++;
    end
    if (wr_fire) begin
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        exp_b = exp_q.pop_front();
        check("wdata", wr_data_seen, exp_b);
      end
      n_writes++;
    end
    status_irq      = (rx_q.size() != 0);
    avalon_readdata = status_irq ? rx_q[0] : 8'h00;

    if (avalon_read) rd_hi++;
    if (avalon_write) wr_hi++;
    if (avalon_read && !rd_prev && lvl_prev == 4) rd_when_full++;
    if (int'(fifo_lvl) > max_lvl) max_lvl = int'(fifo_lvl);
    if (avalon_write) begin
      if (!wr_prev) wr_start = avalon_writedata;
      else if (avalon_writedata !== wr_start) wdata_unstable++;
    end
    rd_prev  = avalon_read;
    wr_prev  = avalon_write;
    lvl_prev = int'(fifo_lvl);

    wait_v = 1'b0;
    if (avalon_read) begin
      if (rd_cnt < rd_stall) begin wait_v = 1'b1; rd_cnt++; end
      else rd_cnt = 0;
    end else rd_cnt = 0;
    if (avalon_write) begin
      if (wr_cnt < wr_stall) begin wait_v = 1'b1; wr_cnt++; end
      else wr_cnt = 0;
    end else wr_cnt = 0;
    avalon_waitrequest = wait_v;
    rd_fire      = avalon_read && !wait_v && rst;
    wr_fire      = avalon_write && !wait_v && rst;
    wr_data_seen = avalon_writedata;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (n_writes >= target) break;
      step(1);
    end
    check(tag, n_writes, target);
  endtask

  initial begin
    int s_rd, s_wr, s_full, wt;

    // Reset state
    step(3);
    check("rst_read", avalon_read, 0);
    check("rst_write", avalon_write, 0);
    check("rst_wdata", avalon_writedata, 8'h00);
    check("rst_cnt_rx", cnt_rx, 0);
    check("rst_cnt_err", cnt_err, 0);
    check("rst_lvl", fifo_lvl, 0);
    rst = 1'b1;
    step(2);

    // Single echo, no stalls
    en = 1'b1;
    s_rd = rd_hi; s_wr = wr_hi; wt = n_writes + 1;
    rx_q.push_back(8'h41);
    wait_writes(wt, 40, "echo_done");
    step(2);
    check("echo_rd_cycles", rd_hi - s_rd, 1);
    check("echo_wr_cycles", wr_hi - s_wr, 1);
    check("echo_cnt_rx", cnt_rx, 1);
    check("echo_lvl", fifo_lvl, 0);

    // Waitrequest stall of 3 cycles on both read and write
    rd_stall = 3; wr_stall = 3;
    s_rd = rd_hi; s_wr = wr_hi; wt = n_writes + 1;
    rx_q.push_back(8'h5a);
    wait_writes(wt, 60, "stall_done");
    step(2);
    check("stall_rd_cycles", rd_hi - s_rd, 4);
    check("stall_wr_cycles", wr_hi - s_wr, 4);
    check("stall_wdata_stable", wdata_unstable, 0);
    check("stall_cnt_rx", cnt_rx, 2);
    check("stall_lvl", fifo_lvl, 0);

    // Burst of 5 bytes with stalled writes: FIFO fills to 4, order preserved
    rd_stall = 0; wr_stall = 3;
    s_full = rd_when_full; wt = n_writes + 5;
    for (int b = 1; b <= 5; b++) rx_q.push_back(8'(b));
    wait_writes(wt, 200, "burst_done");
    step(2);
    check("burst_max_lvl", max_lvl, 4);
    check("burst_rd_when_full", rd_when_full - s_full, 0);
    check("burst_cnt_rx", cnt_rx, 7);
    check("burst_lvl", fifo_lvl, 0);

    // Disabled with a byte pending: no read for 20 cycles
    wr_stall = 0;
    en = 1'b0;
    step(2);
    s_rd = rd_hi;
    rx_q.push_back(8'h33);
    step(20);
    check("dis_no_read", rd_hi - s_rd, 0);

    // Re-enable with stalled write, then drop en mid-write
    wr_stall = 6;
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (avalon_write) break;
      step(1);
    end
    check("dis_wr_started", avalon_write, 1);
    en = 1'b0;
    wt = n_writes + 1;
    rx_q.push_back(8'h7e);
    step(1);
    s_rd = rd_hi;
    step(20);
    check("dis_wr_completed", n_writes, wt);
    check("dis_bus_idle_rd", rd_hi - s_rd, 0);
    check("dis_bus_idle_wr", avalon_write, 0);
    check("dis_lvl", fifo_lvl, 0);
    wr_stall = 0;
    en = 1'b1;
    wait_writes(wt + 1, 40, "dis_drain");
    step(2);

    // Reset while a read is stalled and the FIFO holds two bytes
    en = 1'b0;
    step(2);
    rx_q.push_back(8'hc1);
    rx_q.push_back(8'hc2);
    rx_q.push_back(8'hc3);
    s_rd = n_reads;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (n_reads >= s_rd + 2) break;
      step(1);
    end
    rd_stall = 1000;
    step(4);
    check("mid_rd_active", avalon_read, 1);
    check("mid_rd_lvl", fifo_lvl, 2);
    rst = 1'b0;
    exp_q.delete();
    step(1);
    check("mid_rst_read", avalon_read, 0);
    check("mid_rst_lvl", fifo_lvl, 0);
    check("mid_rst_cnt_rx", cnt_rx, 0);
    rst = 1'b1;
    rd_stall = 0;
    wt = n_writes + 1;
    wait_writes(wt, 60, "mid_rst_recover");
    step(2);
    check("mid_rst_cnt_rx_after", cnt_rx, 1);

    // Error counter: a held level counts once, pulses saturate at FF
    en = 1'b0;
    status_err = 1'b1;
    step(10);
    status_err = 1'b0;
    step(3);
    check("err_level_once", cnt_err, 1);
    for (int p = 0; p < 253; p++) begin
      status_err = 1'b1; step(1);
      status_err = 1'b0; step(1);
    end
    step(2);
    check("err_fe", cnt_err, 8'hFE);
    for (int p = 0; p < 47; p++) begin
      status_err = 1'b1; step(1);
      status_err = 1'b0; step(1);
    end
    step(2);
    check("err_sat", cnt_err, 8'hFF);

    check("sb_empty", exp_q.size(), 0);
    check("rx_drained", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
